// File: rtl/nes_ctrl_pkg.sv
// Shared constants and state encoding for the NES pad reader and its register front-end.
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } nes_state_e;

  localparam int unsigned NES_BITS    = 8;
  localparam int unsigned LATCH_TICKS = 2;

  // Bit positions inside the published button byte (1 = pressed).
  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_tick_gen.sv
// Free-running prescaler: emits a 1-cycle tick on the last of every TICK_DIV clocks.
module nes_tick_gen #(
  parameter int unsigned TICK_DIV = 384
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/nes_serial_reader.sv
// NES pad engine: latches the pad, clocks out 8 button bits and publishes an active-high
// button byte with a 1-cycle valid strobe, either on request or by periodic auto-poll.
module nes_serial_reader
  import nes_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 384,
  parameter int unsigned POLL_TICKS = 2778
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       poll_en,
  input  logic       start,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [7:0] buttons,
  output logic       buttons_valid,
  output logic       busy
);

  localparam int unsigned PollW = (POLL_TICKS > 1) ? $clog2(POLL_TICKS) : 1;
  localparam logic [PollW-1:0] PollReload = PollW'(POLL_TICKS - 1);
  localparam logic [2:0] LastBit = 3'(NES_BITS - 1);
  localparam logic [1:0] LatchLast = 2'(LATCH_TICKS - 1);

  logic tick;

  nes_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  nes_state_e           state_q, state_d;
  logic [1:0]           latch_cnt_q, latch_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [NES_BITS-1:0]  shift_q, shift_d;
  logic [PollW-1:0]     poll_cnt_q, poll_cnt_d;
  logic                 pending_q, pending_d;
  logic [7:0]           buttons_q, buttons_d;
  logic                 valid_q, latch_q, clk_q, busy_q;
  logic                 frame_go;

  always_comb begin
    state_d     = state_q;
    latch_cnt_d = latch_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    poll_cnt_d  = poll_cnt_q;
    pending_d   = pending_q;
    buttons_d   = buttons_q;

    frame_go = tick && (state_q == StIdle) &&
               (pending_q || (poll_en && (poll_cnt_q == '0)));

    if (frame_go) begin
      poll_cnt_d = PollReload;
    end else if (tick && (poll_cnt_q != '0)) begin
      poll_cnt_d = poll_cnt_q - 1'b1;
    end

    // A frame start always consumes the request, even one arriving in the same cycle.
    if (frame_go) begin
      pending_d = 1'b0;
    end else if (start && (state_q == StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (frame_go) begin
          state_d     = StLatch;
          latch_cnt_d = '0;
          bit_idx_d   = '0;
        end
      end
      StLatch: begin
        if (tick) begin
          if (latch_cnt_q == LatchLast) begin
            state_d = StLow;
          end else begin
            latch_cnt_d = latch_cnt_q + 1'b1;
          end
        end
      end
      StLow: begin
        if (tick) begin
          shift_d = {shift_q[NES_BITS-2:0], ~nes_data};
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (tick) begin
          if (bit_idx_q == LastBit) begin
            state_d   = StDone;
            // Loaded on entry so the byte and the valid strobe appear together.
            buttons_d = shift_q;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            state_d   = StLow;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      latch_cnt_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      poll_cnt_q  <= '0;
      pending_q   <= 1'b0;
      buttons_q   <= 8'h00;
      valid_q     <= 1'b0;
      latch_q     <= 1'b0;
      clk_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      latch_cnt_q <= latch_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      poll_cnt_q  <= poll_cnt_d;
      pending_q   <= pending_d;
      buttons_q   <= buttons_d;
      valid_q     <= (state_d == StDone);
      latch_q     <= (state_d == StLatch);
      clk_q       <= (state_d != StLow);
      busy_q      <= (state_d != StIdle);
    end
  end

  assign nes_latch     = latch_q;
  assign nes_clk       = clk_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_nes_serial_reader.sv
// Scoreboard bench for nes_serial_reader with a behavioural NES pad on the serial pins.
module tb_nes_serial_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       poll_en = 1'b0;
  logic       start = 1'b0;
  logic       nes_data;
  logic       nes_latch, nes_clk, buttons_valid, busy;
  logic [7:0] buttons;

  nes_serial_reader #(
    .TICK_DIV  (4),
    .POLL_TICKS(20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .poll_en      (poll_en),
    .start        (start),
    .nes_data     (nes_data),
    .nes_latch    (nes_latch),
    .nes_clk      (nes_clk),
    .buttons      (buttons),
    .buttons_valid(buttons_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pad model: parallel load while latched, shift on nes_clk rising edge.
  logic [7:0] pad_buttons = 8'h00;
  logic       pad_present = 1'b1;
  logic [7:0] pad_q = 8'h00;
  logic       pad_clk_prev = 1'b1;

  assign nes_data = pad_present ? ~pad_q[7] : 1'b1;

  always @(posedge clk) begin
    if (nes_latch) pad_q <= pad_buttons;
    else if (nes_clk && !pad_clk_prev) pad_q <= {pad_q[6:0], 1'b0};
    pad_clk_prev <= nes_clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and protocol monitor.
  logic [7:0] sb[$];
  int valid_count = 0, rise_count = 0, busy_falls = 0;
  int fall_cnt = 0, rise_cnt = 0, latch_w = 0, low_w = 0;
  int rise_times[$];
  logic latch_prev = 1'b0, nclk_prev = 1'b1, valid_prev = 1'b0, busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      low_w   = 0;
      latch_w = 0;
    end else begin
      if (buttons_valid) begin
        valid_count++;
        chk("valid_width", 32'(valid_prev), 32'd0);
        chk("clk_pulses", 32'(fall_cnt), 32'd8);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk("buttons", 32'(buttons), 32'(sb.pop_front()));
      end
      if (nes_latch && !latch_prev) begin
        rise_count++;
        rise_times.push_back(cyc);
        fall_cnt = 0;
        rise_cnt = 0;
        latch_w  = 0;
      end
      if (nes_latch) latch_w++;
      if (!nes_latch && latch_prev) chk("latch_width", 32'(latch_w), 32'd8);
      if (!nes_clk && nclk_prev) fall_cnt++;
      if (!nes_clk) low_w++;
      if (nes_clk && !nclk_prev) begin
        rise_cnt++;
        chk("clk_low_width", 32'(low_w), 32'd4);
        low_w = 0;
      end
      if (busy_prev && !busy) busy_falls++;
    end
    latch_prev = nes_latch;
    nclk_prev  = nes_clk;
    valid_prev = buttons_valid;
    busy_prev  = busy;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int target);
    int k = 0;
    while (valid_count < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("valid_timeout", 32'(valid_count >= target), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_v, base_r, base_b, k;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_latch", 32'(nes_latch), 32'd0);
    chk("rst_clk", 32'(nes_clk), 32'd1);
    chk("rst_buttons", 32'(buttons), 32'h00);
    chk("rst_valid", 32'(buttons_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // A + Start + Right
    pad_buttons = 8'h91;
    sb.push_back(8'h91);
    pulse_start();
    wait_valid(1);
    wait_cycles(3);
    chk("idle_after_frame", 32'(busy), 32'd0);

    // Absent pad, then all pressed
    pad_present = 1'b0;
    sb.push_back(8'h00);
    pulse_start();
    wait_valid(2);
    pad_present = 1'b1;
    pad_buttons = 8'hFF;
    sb.push_back(8'hFF);
    pulse_start();
    wait_valid(3);
    wait_cycles(100);

    // Auto-poll: three frames, poll_en dropped mid third frame
    pad_buttons = 8'h5A;
    repeat (3) sb.push_back(8'h5A);
    base_r = rise_count;
    poll_en = 1'b1;
    k = 0;
    while (rise_count < base_r + 3 && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("poll_timeout", 32'(rise_count >= base_r + 3), 32'd1);
    wait_cycles(20);
    poll_en = 1'b0;
    wait_valid(6);
    if (rise_times.size() >= base_r + 3) begin
      chk("poll_period_1", 32'(rise_times[base_r+1] - rise_times[base_r]), 32'd80);
      chk("poll_period_2", 32'(rise_times[base_r+2] - rise_times[base_r+1]), 32'd80);
    end
    base_v = valid_count;
    base_r = rise_count;
    wait_cycles(200);
    chk("poll_stopped_valid", 32'(valid_count - base_v), 32'd0);
    chk("poll_stopped_latch", 32'(rise_count - base_r), 32'd0);

    // start during 5th LOW phase is ignored
    pad_buttons = 8'h3C;
    sb.push_back(8'h3C);
    base_v = valid_count;
    base_r = rise_count;
    base_b = busy_falls;
    pulse_start();
    k = 0;
    while (!(rise_count > base_r && fall_cnt >= 5) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("low5_timeout", 32'(fall_cnt == 5 && !nes_clk), 32'd1);
    pulse_start();
    wait_valid(base_v + 1);
    wait_cycles(200);
    chk("busy_falls", 32'(busy_falls - base_b), 32'd1);
    chk("single_valid", 32'(valid_count - base_v), 32'd1);
    chk("single_latch", 32'(rise_count - base_r), 32'd1);

    // rst during bit-4 HIGH phase
    pad_buttons = 8'hC3;
    base_v = valid_count;
    base_r = rise_count;
    pulse_start();
    k = 0;
    while (!(rise_count > base_r && rise_cnt >= 5) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("high4_timeout", 32'(rise_cnt == 5 && nes_clk), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_clk", 32'(nes_clk), 32'd1);
    chk("abort_latch", 32'(nes_latch), 32'd0);
    chk("abort_buttons", 32'(buttons), 32'h00);
    chk("abort_busy", 32'(busy), 32'd0);
    wait_cycles(100);
    chk("abort_no_valid", 32'(valid_count - base_v), 32'd0);
    pad_buttons = 8'hA5;
    sb.push_back(8'hA5);
    pulse_start();
    wait_valid(base_v + 1);
    wait_cycles(10);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
